// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: walks the operands MSB-first, DIGIT bits
// per clock, and stops at the first chunk that differs.
// Signed ordering comes from flipping the sign bit of both operands at
// capture time, so the datapath only ever does unsigned chunk compares.

// One chunk of the operand pair compared as unsigned values.
module smc_chunk_cmp #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt
);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             signed_mode,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    output logic                             busy,
    output logic                             done,
    output logic                             lesser,
    output logic                             greater,
    output logic                             equal,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0] cycles
);
    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CYC_W = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_magnitude_comparator: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        op_a, op_b;
    logic [IDX_W-1:0]        idx;
    logic [N-1:0][DIGIT-1:0] chunk_a, chunk_b;
    logic [N-1:0]            lt_vec, gt_vec;
    logic                    chunk_lt, chunk_gt, last;

    // Split the latched operands into MSB-first chunks, one comparator each.
    generate
        for (genvar i = 0; i < N; i++) begin : g_chunk
            assign chunk_a[i] = op_a[WIDTH-1-i*DIGIT -: DIGIT];
            assign chunk_b[i] = op_b[WIDTH-1-i*DIGIT -: DIGIT];
            smc_chunk_cmp #(.DIGIT(DIGIT)) u_cmp (
                .a  (chunk_a[i]),
                .b  (chunk_b[i]),
                .lt (lt_vec[i]),
                .gt (gt_vec[i])
            );
        end
    endgenerate

    assign chunk_lt = lt_vec[idx];
    assign chunk_gt = gt_vec[idx];
    assign last     = (idx == IDX_W'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: leave COMPARE on the first differing chunk or the last chunk.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMPARE;
            COMPARE: if (chunk_lt || chunk_gt || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output.
    always_comb begin
        busy = (state == COMPARE);
    end

    // Datapath: operand capture, chunk index and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            idx     <= '0;
            done    <= 1'b0;
            lesser  <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
            cycles  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a ^ (signed_mode ? MSB : '0);
                        op_b    <= b ^ (signed_mode ? MSB : '0);
                        idx     <= '0;
                        lesser  <= 1'b0;
                        greater <= 1'b0;
                        equal   <= 1'b0;
                        cycles  <= '0;
                    end
                end
                COMPARE: begin
                    if (chunk_lt || chunk_gt) begin
                        lesser  <= chunk_lt;
                        greater <= chunk_gt;
                        cycles  <= CYC_W'(idx) + CYC_W'(1);
                        done    <= 1'b1;
                    end else if (last) begin
                        equal  <= 1'b1;
                        cycles <= CYC_W'(N);
                        done   <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: one instance with DIGIT=1 and
// one with DIGIT=4, a vector table plus hand-written busy/reset sequences.
module tb_seq_magnitude_comparator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = '0, b = '0;

    logic       busy1, done1, lt1, gt1, eq1;
    logic [3:0] cyc1;
    logic       busy4, done4, lt4, gt4, eq4;
    logic [1:0] cyc4;

    int checks = 0;
    int errors = 0;
    int cur = 0;

    logic o_busy, o_done, o_lt, o_gt, o_eq;
    int   o_cyc;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy1), .done(done1), .lesser(lt1),
        .greater(gt1), .equal(eq1), .cycles(cyc1)
    );

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy4), .done(done4), .lesser(lt4),
        .greater(gt4), .equal(eq4), .cycles(cyc4)
    );

    // Route the selected instance onto a common set of observation signals.
    always_comb begin
        if (cur == 0) begin
            o_busy = busy1; o_done = done1; o_lt = lt1; o_gt = gt1; o_eq = eq1;
            o_cyc  = int'(cyc1);
        end else begin
            o_busy = busy4; o_done = done4; o_lt = lt4; o_gt = gt4; o_eq = eq4;
            o_cyc  = int'(cyc4);
        end
    end

    typedef struct {
        int         sel;
        logic       smode;
        logic [7:0] va;
        logic [7:0] vb;
        logic       e_lt;
        logic       e_gt;
        logic       e_eq;
        int         e_cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur == 0) start1 = v;
        else          start4 = v;
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, " busy"},    int'(o_busy), 0);
        chk({name, " done"},    int'(o_done), 0);
        chk({name, " lesser"},  int'(o_lt),   0);
        chk({name, " greater"}, int'(o_gt),   0);
        chk({name, " equal"},   int'(o_eq),   0);
        chk({name, " cycles"},  o_cyc,        0);
    endtask

    task automatic chk_result(input string name, input logic l, input logic g,
                              input logic e, input int c);
        chk({name, " lesser"},  int'(o_lt), int'(l));
        chk({name, " greater"}, int'(o_gt), int'(g));
        chk({name, " equal"},   int'(o_eq), int'(e));
        chk({name, " cycles"},  o_cyc,      c);
    endtask

    // Count edges after capture until done is seen; -1 if the bound expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (o_done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;

        //        sel smode  a      b      lt gt eq cyc
        vecs[0]  = '{0, 1'b0, 8'd111, 8'd250, 1, 0, 0, 1};
        vecs[1]  = '{0, 1'b0, 8'd255, 8'd255, 0, 0, 1, 8};
        vecs[2]  = '{0, 1'b0, 8'd79,  8'd74,  0, 1, 0, 6};
        vecs[3]  = '{1, 1'b0, 8'd79,  8'd74,  0, 1, 0, 2};
        vecs[4]  = '{1, 1'b0, 8'd96,  8'd96,  0, 0, 1, 2};
        vecs[5]  = '{0, 1'b1, 8'h80,  8'h7F,  1, 0, 0, 1};
        vecs[6]  = '{0, 1'b0, 8'h80,  8'h7F,  0, 1, 0, 1};
        vecs[7]  = '{1, 1'b1, 8'h80,  8'h7F,  1, 0, 0, 1};
        vecs[8]  = '{0, 1'b1, 8'hFF,  8'h01,  1, 0, 0, 1};
        vecs[9]  = '{0, 1'b1, 8'hFE,  8'hFF,  1, 0, 0, 8};
        vecs[10] = '{1, 1'b0, 8'h3C,  8'h3D,  1, 0, 0, 2};
        vecs[11] = '{0, 1'b0, 8'h00,  8'h00,  0, 0, 1, 8};

        // Reset state on both instances.
        #12;
        cur = 0; #1 chk_idle_zero("reset d1");
        cur = 1; #1 chk_idle_zero("reset d4");
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            cur = vecs[i].sel;
            @(negedge clk);
            a = vecs[i].va; b = vecs[i].vb; signed_mode = vecs[i].smode;
            set_start(1'b1);
            @(posedge clk); #1;
            set_start(1'b0);
            a = ~vecs[i].va; b = ~vecs[i].vb; signed_mode = ~vecs[i].smode;
            chk($sformatf("v%0d busy", i), int'(o_busy), 1);
            chk($sformatf("v%0d cleared", i), int'(o_lt | o_gt | o_eq), 0);
            wait_done(lat);
            chk($sformatf("v%0d latency", i), lat, vecs[i].e_cyc);
            chk_result($sformatf("v%0d", i), vecs[i].e_lt, vecs[i].e_gt,
                       vecs[i].e_eq, vecs[i].e_cyc);
            @(posedge clk); #1;
            chk($sformatf("v%0d done pulse", i), int'(o_done), 0);
            chk($sformatf("v%0d busy after", i), int'(o_busy), 0);
            chk_result($sformatf("v%0d held", i), vecs[i].e_lt, vecs[i].e_gt,
                       vecs[i].e_eq, vecs[i].e_cyc);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        cur = 0;
        @(negedge clk);
        a = 8'hAA; b = 8'hAA; signed_mode = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                start1 = 1'b1; a = 8'h00; b = 8'hFF;
            end
            if (k == 4) start1 = 1'b0;
            if (o_done) begin
                lat = k;
                break;
            end
        end
        chk("busy-start latency", lat, 8);
        chk_result("busy-start", 1'b0, 1'b0, 1'b1, 8);
        a = 8'h01; b = 8'h00; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("done-cycle start busy", int'(o_busy), 1);
        chk("done-cycle start done", int'(o_done), 0);
        chk_result("done-cycle start cleared", 1'b0, 1'b0, 1'b0, 0);
        wait_done(lat);
        chk("done-cycle start latency", lat, 8);
        chk_result("done-cycle start", 1'b0, 1'b1, 1'b0, 8);

        // Reset mid-compare between edges, then a clean run after release.
        @(negedge clk);
        a = 8'h00; b = 8'h00; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_idle_zero("mid reset");
        @(posedge clk); #1;
        chk_idle_zero("held reset");
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'd5; b = 8'd3; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("post-reset busy", int'(o_busy), 1);
        wait_done(lat);
        chk("post-reset latency", lat, 6);
        chk_result("post-reset", 1'b0, 1'b1, 1'b0, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
